// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, packed control word and FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11,
        OP_MUL  = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_wr;
        logic       jal;
        logic [1:0] dsize;
        alu_op_e    alu_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        ALU_RDY  = 2'd1,
        MUL_BUSY = 2'd2,
        MUL_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/exec_stage_if.sv
// Upstream/downstream handshake and operand bus of the execute stage.
interface exec_stage_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) ();
    import exec_pkg::*;

    logic            in_valid;
    logic            in_ready;
    ctrl_t           in_ctrl;
    logic [XLEN-1:0] in_bus_a;
    logic [XLEN-1:0] in_bus_b;
    logic [XLEN-1:0] in_imm;
    logic [RAW-1:0]  in_rd;
    logic [RAW-1:0]  in_rt;
    logic [1:0]      fwd_sel_a;
    logic [1:0]      fwd_sel_b;
    logic [XLEN-1:0] fwd_mem_data;
    logic [XLEN-1:0] fwd_wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    ctrl_t           out_ctrl;
    logic [XLEN-1:0] out_alu;
    logic [XLEN-1:0] out_bus_b;
    logic [RAW-1:0]  out_rw;

    modport master (
        output in_valid, in_ctrl, in_bus_a, in_bus_b, in_imm, in_rd, in_rt,
               fwd_sel_a, fwd_sel_b, fwd_mem_data, fwd_wb_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu, out_bus_b, out_rw
    );

    modport slave (
        input  in_valid, in_ctrl, in_bus_a, in_bus_b, in_imm, in_rd, in_rt,
               fwd_sel_a, fwd_sel_b, fwd_mem_data, fwd_wb_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu, out_bus_b, out_rw
    );

endinterface

// File: rtl/exec_mul.sv
// Radix-2 shift-add multiplier, one multiplier bit per cycle, low XLEN bits of the product.
module exec_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN + 1);

    logic [XLEN-1:0] mcand, mplier, acc;
    logic [CW-1:0]   cnt;

    // done marks the cycle whose edge performs the final iteration
    assign done   = busy && (cnt == CW'(1));
    assign result = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(XLEN);
            busy   <= 1'b1;
        end else if (busy) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: operand forwarding, single-cycle ALU and an iterative multiplier behind
// a valid/ready handshake with a one-entry output register.
module exec_stage
    import exec_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int RAW    = 5,
    parameter int MUL_EN = 1
) (
    input logic         clk,
    input logic         rst_n,
    exec_stage_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    state_e          state, nextState;
    ctrl_t           ctrlQ, outCtrl;
    logic [XLEN-1:0] aQ, bQ, immQ;
    logic [RAW-1:0]  rwQ;
    logic [XLEN-1:0] fwdA, fwdB, op2In, op2, aluRes, mulRes;
    logic [SHW-1:0]  sh;
    logic            accept, isMulIn, outValid, inReady, mulStart, mulBusy, mulDone;

    function automatic logic [XLEN-1:0] fwdMux(input logic [1:0] sel,
                                               input logic [XLEN-1:0] busV, memV, wbV);
        case (sel)
            2'd1:    return memV;
            2'd2:    return wbV;
            default: return busV;
        endcase
    endfunction

    assign fwdA     = fwdMux(bus.fwd_sel_a, bus.in_bus_a, bus.fwd_mem_data, bus.fwd_wb_data);
    assign fwdB     = fwdMux(bus.fwd_sel_b, bus.in_bus_b, bus.fwd_mem_data, bus.fwd_wb_data);
    assign op2In    = bus.in_ctrl.alu_src ? bus.in_imm : fwdB;
    assign isMulIn  = (MUL_EN != 0) && (bus.in_ctrl.alu_op == OP_MUL);
    assign mulStart = accept && isMulIn;

    always_comb begin
        outValid  = (state == ALU_RDY) || (state == MUL_DONE);
        inReady   = (state == EMPTY) || (outValid && bus.out_ready);
        accept    = bus.in_valid && inReady && !bus.flush;
        nextState = state;
        if (bus.flush) begin
            nextState = EMPTY;
        end else begin
            case (state)
                EMPTY:
                    if (accept) nextState = isMulIn ? MUL_BUSY : ALU_RDY;
                ALU_RDY, MUL_DONE:
                    if (bus.out_ready) nextState = accept ? (isMulIn ? MUL_BUSY : ALU_RDY) : EMPTY;
                MUL_BUSY:
                    if (mulDone)       nextState = MUL_DONE;
                    else if (!mulBusy) nextState = EMPTY;
                default: nextState = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= nextState;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrlQ <= '0;
            aQ    <= '0;
            bQ    <= '0;
            immQ  <= '0;
            rwQ   <= '0;
        end else if (accept) begin
            ctrlQ <= bus.in_ctrl;
            aQ    <= fwdA;
            bQ    <= fwdB;
            immQ  <= bus.in_imm;
            rwQ   <= bus.in_ctrl.reg_dst ? bus.in_rd : bus.in_rt;
        end
    end

    // ALU works on the captured operands, so outputs stay stable while stalled
    assign op2 = ctrlQ.alu_src ? immQ : bQ;
    assign sh  = aQ[SHW-1:0];

    always_comb begin
        aluRes = '0;
        case (ctrlQ.alu_op)
            OP_ADD:  aluRes = aQ + op2;
            OP_SUB:  aluRes = aQ - op2;
            OP_AND:  aluRes = aQ & op2;
            OP_OR:   aluRes = aQ | op2;
            OP_XOR:  aluRes = aQ ^ op2;
            OP_NOR:  aluRes = ~(aQ | op2);
            OP_SLT:  aluRes[0] = $signed(aQ) < $signed(op2);
            OP_SLTU: aluRes[0] = aQ < op2;
            OP_SLL:  aluRes = op2 << sh;
            OP_SRL:  aluRes = op2 >> sh;
            OP_SRA:  aluRes = $unsigned($signed(op2) >>> sh);
            OP_LUI:  aluRes = op2 << (XLEN / 2);
            OP_MUL:  aluRes = aQ + op2;   // only visible when the multiplier is absent
            default: aluRes = '0;
        endcase
    end

    if (MUL_EN != 0) begin : gMul
        exec_mul #(.XLEN(XLEN)) uMul (
            .clk   (clk),
            .rst_n (rst_n),
            .start (mulStart),
            .abort (bus.flush),
            .a     (fwdA),
            .b     (op2In),
            .busy  (mulBusy),
            .done  (mulDone),
            .result(mulRes)
        );
    end else begin : gNoMul
        assign mulBusy = 1'b0;
        assign mulDone = 1'b0;
        assign mulRes  = '0;
    end

    always_comb begin
        outCtrl = ctrlQ;
        if (!outValid) begin
            outCtrl.reg_write = 1'b0;
            outCtrl.mem_wr    = 1'b0;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_ctrl  = outCtrl;
    assign bus.out_alu   = (state == MUL_DONE) ? mulRes : aluRes;
    assign bus.out_bus_b = bQ;
    assign bus.out_rw    = rwQ;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU table back-to-back, MUL latency/stall, flush and reset.
module tb_exec_stage;
    import exec_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int NV   = 14;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a, b, imm;
        logic        src;
        logic [1:0]  sa, sb;
        logic [31:0] exp, expB;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nChk  = 0;
    int   nPass = 0;
    vec_t v[NV];

    exec_stage_if #(.XLEN(XLEN), .RAW(RAW)) bus ();

    exec_stage #(.XLEN(XLEN), .RAW(RAW), .MUL_EN(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_bus_a  = '0;
        bus.in_bus_b  = '0;
        bus.in_imm    = '0;
        bus.in_rd     = '0;
        bus.in_rt     = '0;
        bus.fwd_sel_a = 2'd0;
        bus.fwd_sel_b = 2'd0;
    endtask

    task automatic issue(input alu_op_e op, input logic [31:0] a, b, imm, input logic src,
                         input logic [1:0] sa, sb, input logic rdst,
                         input logic [4:0] rd, rt);
        bus.in_valid          = 1'b1;
        bus.in_ctrl           = '0;
        bus.in_ctrl.alu_op    = op;
        bus.in_ctrl.alu_src   = src;
        bus.in_ctrl.reg_dst   = rdst;
        bus.in_ctrl.reg_write = 1'b1;
        bus.in_bus_a          = a;
        bus.in_bus_b          = b;
        bus.in_imm            = imm;
        bus.fwd_sel_a         = sa;
        bus.fwd_sel_b         = sb;
        bus.in_rd             = rd;
        bus.in_rt             = rt;
    endtask

    initial begin
        int busyRdy, busyVld, sawVld;
        logic [4:0] expRw;

        v = '{
            '{OP_ADD,  32'd5,        32'h55,       32'd7,    1'b1, 2'd0, 2'd0, 32'd12,       32'h55},
            '{OP_SUB,  32'h99,       32'd3,        32'd0,    1'b0, 2'd1, 2'd0, 32'h0D,       32'd3},
            '{OP_AND,  32'hF0F0,     32'hFF00,     32'd0,    1'b0, 2'd0, 2'd0, 32'hF000,     32'hFF00},
            '{OP_OR,   32'hF0F0,     32'h0F00,     32'd0,    1'b0, 2'd3, 2'd3, 32'hFFF0,     32'h0F00},
            '{OP_XOR,  32'h0F,       32'hFF,       32'd0,    1'b0, 2'd0, 2'd2, 32'hFF,       32'hF0},
            '{OP_NOR,  32'd0,        32'd0,        32'd0,    1'b0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'd0},
            '{OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd0,    1'b0, 2'd0, 2'd0, 32'd1,        32'd1},
            '{OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,    1'b0, 2'd0, 2'd0, 32'd0,        32'd1},
            '{OP_SLL,  32'd4,        32'd3,        32'd0,    1'b0, 2'd0, 2'd0, 32'h30,       32'd3},
            '{OP_SLL,  32'd33,       32'd1,        32'd0,    1'b0, 2'd0, 2'd0, 32'd2,        32'd1},
            '{OP_SRL,  32'd4,        32'h80000000, 32'd0,    1'b0, 2'd0, 2'd0, 32'h08000000, 32'h80000000},
            '{OP_SRA,  32'd4,        32'h80000000, 32'd0,    1'b0, 2'd0, 2'd0, 32'hF8000000, 32'h80000000},
            '{OP_LUI,  32'd0,        32'd0,        32'h1234, 1'b1, 2'd0, 2'd0, 32'h12340000, 32'd0},
            '{OP_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,    1'b0, 2'd0, 2'd0, 32'd0,        32'd1}
        };

        idle();
        bus.flush        = 1'b0;
        bus.out_ready    = 1'b0;
        bus.fwd_mem_data = 32'h10;
        bus.fwd_wb_data  = 32'hF0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_alu",   64'(bus.out_alu), 64'd0);
        chk("rst_ctrl",  64'(bus.out_ctrl), 64'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;

        // ALU table, one instruction per cycle
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) begin
                expRw = ((i - 1) % 2 == 1) ? 5'(i) : 5'(i + 15);
                chk($sformatf("alu%0d",   i - 1), 64'(bus.out_alu),   64'(v[i-1].exp));
                chk($sformatf("busb%0d",  i - 1), 64'(bus.out_bus_b), 64'(v[i-1].expB));
                chk($sformatf("rw%0d",    i - 1), 64'(bus.out_rw),    64'(expRw));
                chk($sformatf("valid%0d", i - 1), 64'(bus.out_valid), 64'd1);
            end
            if (i < NV) issue(v[i].op, v[i].a, v[i].b, v[i].imm, v[i].src, v[i].sa, v[i].sb,
                              (i % 2) == 1, 5'(i + 1), 5'(i + 16));
            else idle();
            if (i == 1) chk("wr_ctrl", 64'(bus.out_ctrl.reg_write), 64'd1);
        end

        // MUL 0xFFFFFFFF * 2, consumer stalled
        @(negedge clk);
        chk("empty_wr", 64'(bus.out_ctrl.reg_write), 64'd0);
        issue(OP_MUL, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd4, 5'd0);
        bus.out_ready = 1'b0;
        busyRdy = 0;
        busyVld = 0;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            busyRdy += int'(bus.in_ready);
            busyVld += int'(bus.out_valid);
            if (n == 1) begin
                chk("mul_busy_wr", 64'(bus.out_ctrl.reg_write), 64'd0);
                issue(OP_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd5, 5'd0);
            end
        end
        chk("mul_busy_rdy", 64'(busyRdy), 64'd0);
        chk("mul_busy_vld", 64'(busyVld), 64'd0);
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk($sformatf("mul_vld%0d", s), 64'(bus.out_valid), 64'd1);
            chk($sformatf("mul_res%0d", s), 64'(bus.out_alu),   64'hFFFFFFFE);
            chk($sformatf("mul_rw%0d",  s), 64'(bus.out_rw),    64'd4);
            chk($sformatf("stall_rdy%0d", s), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        #1 chk("release_rdy", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("b2b_alu", 64'(bus.out_alu),   64'd42);
        chk("b2b_vld", 64'(bus.out_valid), 64'd1);
        chk("b2b_rw",  64'(bus.out_rw),    64'd5);
        idle();

        // flush at cycle 10 of a MUL, with a competing instruction
        @(negedge clk);
        issue(OP_MUL, 32'd3, 32'd5, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd6, 5'd0);
        @(negedge clk);
        idle();
        repeat (8) @(negedge clk);
        chk("pre_flush_vld", 64'(bus.out_valid), 64'd0);
        bus.flush = 1'b1;
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd7, 5'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        idle();
        chk("flush_rdy", 64'(bus.in_ready), 64'd1);
        chk("flush_vld", 64'(bus.out_valid), 64'd0);
        chk("flush_wr",  64'(bus.out_ctrl.reg_write), 64'd0);
        sawVld = 0;
        repeat (40) begin
            @(negedge clk);
            sawVld += int'(bus.out_valid);
        end
        chk("flush_never_vld", 64'(sawVld), 64'd0);

        // async reset mid-MUL
        issue(OP_MUL, 32'hFFFF, 32'hFFFF, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd9, 5'd0);
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        chk("pre_rst_busb", 64'(bus.out_bus_b), 64'hFFFF);
        chk("pre_rst_rdy",  64'(bus.in_ready),  64'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_vld",  64'(bus.out_valid), 64'd0);
        chk("arst_alu",  64'(bus.out_alu),   64'd0);
        chk("arst_busb", 64'(bus.out_bus_b), 64'd0);
        chk("arst_rw",   64'(bus.out_rw),    64'd0);
        chk("arst_ctrl", 64'(bus.out_ctrl),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_rdy", 64'(bus.in_ready), 64'd1);
        issue(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 2'd0, 2'd0, 1'b1, 5'd2, 5'd0);
        @(negedge clk);
        chk("post_rst_add", 64'(bus.out_alu),   64'd2);
        chk("post_rst_vld", 64'(bus.out_valid), 64'd1);
        idle();
        @(negedge clk);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
